// File: rtl/proc_pkg.sv
// Shared processor definitions: accumulator word width and word type.
package proc_pkg;
   localparam int unsigned WORD_W = 8;
   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/out_fifo.sv
// out_fifo: storage array with read/write pointers and an occupancy count.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (clears storage too)
//   push, din  - write din at the write pointer (caller guarantees not full)
//   pop        - advance the read pointer (caller guarantees not empty)
//   dout       - entry at the read pointer
//   count      - number of entries held, 0..DEPTH
module out_fifo
   import proc_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = WORD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers are exactly log2(DEPTH) wide, so natural overflow is the
   // modulo-DEPTH wrap; full vs. empty is told apart by count alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/out_port.sv
// out_port: processor output port. OUT strobes (wr_en) capture the
// accumulator into a FIFO that drains over a valid/ready handshake.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   wr_en, ac_q         - OUT strobe and accumulator value to capture
//   full                - FIFO holds DEPTH entries; control must stall OUT
//   overflow            - sticky: a write was dropped while full
//   count               - entries currently queued
//   out_data, out_valid - head-of-queue byte and its valid flag
//   out_ready           - consumer accepts out_data on this edge
module out_port
   import proc_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = WORD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         ac_q,
   output logic                     full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic push;
   logic pop;

   // Status comes only from registered count, so there is no path from
   // wr_en/out_ready to any output.
   assign out_valid = (count != '0);
   assign full      = (count == CW'(DEPTH));

   // Eligibility uses the pre-edge full: a write while full is dropped even
   // if a pop frees a slot on the same edge.
   assign push = wr_en & ~full;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end
   end

   out_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (ac_q),
      .dout  (out_data),
      .count (count)
   );

endmodule

// File: tb/tb_out_port.sv
// Self-checking bench for out_port: a queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_out_port;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] ac_q;
   logic       full;
   logic       overflow;
   logic [2:0] count;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // reference model state
   logic [7:0] q[$];
   logic [7:0] out_log[$];
   bit         m_ovf;
   bit         do_pop;
   bit         do_push;

   out_port #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .ac_q      (ac_q),
      .full      (full),
      .overflow  (overflow),
      .count     (count),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a plain queue of accepted bytes; pop before push within an edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         do_pop  = (q.size() != 0) && out_ready;
         do_push = wr_en && (q.size() < DEPTH);
         if (wr_en && q.size() == DEPTH) m_ovf = 1'b1;
         if (do_pop) out_log.push_back(q.pop_front());
         if (do_push) q.push_back(ac_q);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("count", 32'(count), q.size());
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("full", 32'(full), 32'(q.size() == DEPTH));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
      end
   end

   task automatic cyc(input logic w, input logic [7:0] d, input logic r);
      wr_en     = w;
      ac_q      = d;
      out_ready = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_data", 32'(out_data), 0);
   endtask

   initial begin
      int unsigned idx;
      int unsigned guard;
      logic w;

      rst = 1'b1; wr_en = 1'b0; ac_q = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      rst = 1'b0;

      // ordering
      cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
      chk("ord_count3", 32'(count), 3);
      chk("ord_head", 32'(out_data), 32'h11);
      cyc(0, 0, 1);
      chk("ord_pop1", 32'(out_data), 32'h22);
      cyc(0, 0, 1);
      chk("ord_pop2", 32'(out_data), 32'h33);
      cyc(0, 0, 1);
      chk("ord_empty", 32'(out_valid), 0);
      chk("ord_count0", 32'(count), 0);

      // full and overflow
      for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0);
      chk("full_set", 32'(full), 1);
      chk("full_count", 32'(count), 4);
      cyc(1, 8'hA4, 1);
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 3);
      chk("ovf_head", 32'(out_data), 32'hA1);
      chk("ovf_full_clr", 32'(full), 0);
      repeat (3) cyc(0, 0, 1);
      chk("ovf_drained", 32'(out_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);

      // wrap-around with random ready
      out_log.delete();
      idx = 0;
      guard = 0;
      while ((idx < 10 || q.size() != 0) && guard < 200) begin
         w = (idx < 10) && (q.size() < DEPTH);
         cyc(w, 8'(idx), 1'($urandom_range(0, 1)));
         if (w) idx++;
         guard++;
      end
      chk("wrap_timeout", 32'(guard < 200), 1);
      chk("wrap_len", out_log.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < out_log.size()) chk("wrap_seq", 32'(out_log[i]), i);
      end

      // simultaneous push/pop at count = 2
      cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
      chk("sim_count2", 32'(count), 2);
      cyc(1, 8'h55, 1);
      chk("sim_count_hold", 32'(count), 2);
      chk("sim_head", 32'(out_data), 32'h02);
      cyc(0, 0, 1);
      chk("sim_third", 32'(out_data), 32'h55);
      cyc(0, 0, 1);
      chk("sim_empty", 32'(out_valid), 0);

      // reset mid-transfer
      cyc(1, 8'h61, 0); cyc(1, 8'h62, 0); cyc(1, 8'h63, 0);
      wr_en = 1'b0;
      out_ready = 1'b1;
      #2 rst = 1'b1;
      #1 chk_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 8'h7E, 0);
      chk("post_rst_data", 32'(out_data), 32'h7E);
      chk("post_rst_valid", 32'(out_valid), 1);
      chk("post_rst_ovf", 32'(overflow), 0);
      cyc(0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
